frame_capture: RTL and testbench
================================

FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 The block SHALL have parameter PAYLOAD_BITS, default 8, giving the number of payload bits per frame (legal range 1..16).
REQ-002 The block SHALL have parameter PARITY_EN, default 1, where 1 means one even-parity bit follows the payload and 0 means no parity bit.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data, input, 1 bit: serial bit stream, LSB first, the same stream fed to the upstream sync detector.
REQ-006 The block SHALL have port detected, input, 1 bit: sync-found flag from the upstream sync detector.
REQ-007 The block SHALL have port frame_data, output, PAYLOAD_BITS bits: last captured payload.
REQ-008 The block SHALL have port frame_valid, output, 1 bit: single-cycle strobe marking frame_data as new.
REQ-009 The block SHALL have port parity_error, output, 1 bit: qualified by frame_valid; 1 means the parity check failed.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a frame is being captured.
REQ-011 The block SHALL have port frame_count, output, 8 bits: count of frames received without error.
REQ-012 The block SHALL use one clock; reset SHALL be asynchronous and active-low; ports SHALL be named clk and Reset.

Function
REQ-013 The FSM SHALL have states IDLE, RECV and PARITY; any unused encoding SHALL return to IDLE on the next edge.
REQ-014 In IDLE, on an edge where detected=1, the block SHALL store data as payload bit 0, set bit_cnt=1 and go to RECV (if PAYLOAD_BITS=1, go straight to completion per REQ-016/017).
REQ-015 In RECV, each edge SHALL store data into payload bit index bit_cnt and increment bit_cnt.
REQ-016 When the last payload bit is stored and PARITY_EN=1, the FSM SHALL go to PARITY.
REQ-017 When the last payload bit is stored and PARITY_EN=0, the FSM SHALL go to IDLE and complete the frame on that edge.
REQ-018 In PARITY, the next edge SHALL sample data as the parity bit, complete the frame, and return to IDLE.
REQ-019 On frame completion, the block SHALL update frame_data with the full payload and hold it until the next completion.
REQ-020 On frame completion, frame_valid SHALL be 1 for exactly the following cycle.
REQ-021 On frame completion, parity_error SHALL equal (XOR of payload bits) XOR (parity bit), and SHALL be 0 when PARITY_EN=0.
REQ-022 frame_data SHALL only change on a completion edge; partial payloads SHALL be kept in an internal shift register.
REQ-023 Latency: frame_valid SHALL rise PAYLOAD_BITS+PARITY_EN edges after the edge at which detected was first sampled high (9 edges at defaults).
REQ-024 detected SHALL be ignored in RECV and PARITY (no restart, no nesting).
REQ-025 detected sampled on the completion edge SHALL be ignored.
REQ-026 detected SHALL be accepted from the first IDLE edge after completion, so back-to-back frames need no gap cycle beyond this.
REQ-027 busy SHALL be 1 exactly when the state is RECV or PARITY, decoded from registered state.
REQ-028 frame_count SHALL increment by 1 on each completion with parity_error=0 and wrap from 255 to 0.
REQ-029 frame_count SHALL be unchanged on error frames.
REQ-030 frame_valid, parity_error and frame_count SHALL be driven from registers only (no combinational path from inputs).

Reset
REQ-031 While Reset=0, the state SHALL be IDLE and bit_cnt SHALL be 0.
REQ-032 While Reset=0, the shift register and frame_data SHALL be 0.
REQ-033 While Reset=0, frame_valid, parity_error, busy and frame_count SHALL be 0.
REQ-034 A reset mid-frame SHALL discard the partial frame with no frame_valid pulse.
REQ-035 After reset release, the block SHALL wait in IDLE for a new detected.

Verification
REQ-036 Good frame: detected=1 at edge E0, data bits 1,0,1,0,0,1,0,1 at E0..E7, parity 0 at E8 -> after E8, frame_data=0xA5, frame_valid=1 for one cycle, parity_error=0, frame_count=1, busy=0.
REQ-037 Bad parity: same payload with parity bit 1 -> frame_valid=1, parity_error=1, frame_data=0xA5, frame_count unchanged.
REQ-038 Ignored detected: detected pulsed at E3 and at E8 inside a frame -> single frame_valid after E8, no restart, busy stays 1 from after E0 until E8.
REQ-039 Back-to-back: second detected at E9 with payload 0x3C and parity 0 -> second frame_valid after E17, frame_data=0x3C, frame_count increments again.
REQ-040 Mid-frame reset: Reset=0 after E4 -> all outputs 0 immediately, no frame_valid; next frame after release captures correctly.
REQ-041 Wrap: 256 consecutive good frames -> frame_count reads 255, then 0.

Source files
------------

// File: rtl/frame_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_capture: captures a serial payload (+ optional even parity) after   |
// | an upstream sync-detect flag, reports it and counts good frames. Rev 1.0  |
// +--------------------------------------------------------------------------+
module frame_capture #(
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY_EN    = 1
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    data,
  input  logic                    detected,
  output logic [PAYLOAD_BITS-1:0] frame_data,
  output logic                    frame_valid,
  output logic                    parity_error,
  output logic                    busy,
  output logic [7:0]              frame_count
);

  localparam int               CNT_W    = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_nxt;
  logic [PAYLOAD_BITS-1:0] shreg, shreg_nxt;
  logic                    complete;
  logic                    parity_bad;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    complete    = 1'b0;
    parity_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (detected) begin
          shreg_nxt    = '0;
          shreg_nxt[0] = data;
          bit_cnt_nxt  = CNT_W'(1);
          if (PAYLOAD_BITS == 1) begin
            if (PARITY_EN != 0) begin
              state_nxt = PARITY;
            end else begin
              complete    = 1'b1;
              bit_cnt_nxt = '0;
            end
          end else begin
            state_nxt = RECV;
          end
        end
      end
      RECV: begin
        for (int i = 0; i < PAYLOAD_BITS; i++) begin
          if (bit_cnt == CNT_W'(i)) shreg_nxt[i] = data;
        end
        bit_cnt_nxt = bit_cnt + CNT_W'(1);
        if (bit_cnt == LAST_IDX) begin
          if (PARITY_EN != 0) begin
            state_nxt = PARITY;
          end else begin
            state_nxt   = IDLE;
            complete    = 1'b1;
            bit_cnt_nxt = '0;
          end
        end
      end
      PARITY: begin
        state_nxt   = IDLE;
        complete    = 1'b1;
        bit_cnt_nxt = '0;
        parity_bad  = (^shreg) ^ data;
      end
      default: begin
        // Unused encoding recovers to IDLE on the next edge.
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      frame_data   <= '0;
      frame_valid  <= 1'b0;
      parity_error <= 1'b0;
      frame_count  <= 8'd0;
    end else begin
      frame_valid <= complete;
      if (complete) begin
        frame_data   <= shreg_nxt;
        parity_error <= parity_bad;
        if (!parity_bad) frame_count <= frame_count + 8'd1;
      end
    end
  end

  assign busy = (state == RECV) || (state == PARITY);

endmodule
`default_nettype wire

// File: tb/tb_frame_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_frame_capture: randomized and directed bench for frame_capture with a  |
// | bit-queue reference model. Rev 1.0                                        |
// +--------------------------------------------------------------------------+
module tb_frame_capture;

  localparam int P  = 8;
  localparam int PE = 1;
  localparam int N  = P + PE;

  logic         clk = 1'b0;
  logic         Reset = 1'b0;
  logic         data = 1'b0;
  logic         detected = 1'b0;
  logic [P-1:0] frame_data;
  logic         frame_valid;
  logic         parity_error;
  logic         busy;
  logic [7:0]   frame_count;

  int vectors = 0;
  int miscompares = 0;

  frame_capture #(.PAYLOAD_BITS(P), .PARITY_EN(PE)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .data         (data),
    .detected     (detected),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .parity_error (parity_error),
    .busy         (busy),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  // Reference model: once a sync is seen while idle, the next N sampled bits
  // (starting with that edge) form one frame.
  int           rem = 0;
  bit           q[$];
  logic [P-1:0] exp_data = '0;
  logic         exp_valid = 1'b0;
  logic         exp_err = 1'b0;
  logic [7:0]   exp_count = 8'd0;
  logic         exp_busy = 1'b0;

  always @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      rem = 0; q.delete();
      exp_data = '0; exp_valid = 1'b0; exp_err = 1'b0;
      exp_count = 8'd0; exp_busy = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (rem == 0) begin
        if (detected) begin
          q.delete();
          q.push_back(data);
          rem = N - 1;
          if (rem == 0) finish_frame();
        end
      end else begin
        q.push_back(data);
        rem--;
        if (rem == 0) finish_frame();
      end
      exp_busy = (rem != 0);
    end
  end

  function automatic void finish_frame();
    logic [P-1:0] p;
    for (int i = 0; i < P; i++) p[i] = q[i];
    exp_data  = p;
    exp_valid = 1'b1;
    exp_err   = (PE != 0) ? ((^p) ^ q[P]) : 1'b0;
    if (!exp_err) exp_count = exp_count + 8'd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("frame_valid", 32'(frame_valid), 32'(exp_valid));
    chk("frame_data", 32'(frame_data), 32'(exp_data));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("frame_count", 32'(frame_count), 32'(exp_count));
    if (exp_valid) chk("parity_error", 32'(parity_error), 32'(exp_err));
  end

  task automatic step(input logic d, input logic det);
    @(posedge clk); #2;
    data = d; detected = det;
  endtask

  task automatic send_frame(input logic [7:0] p, input logic par, input logic noise);
    logic [8:0] bits;
    bits = {par, p};
    for (int i = 0; i < 9; i++)
      step(bits[i], (i == 0) || (noise && (i == 3 || i == 8)));
  endtask

  // Let the completion edge happen, go quiet, and stop on the next negedge.
  task automatic settle();
    @(posedge clk); #2;
    data = 1'b0; detected = 1'b0;
    @(negedge clk);
  endtask

  task automatic lit_outputs(input string tag, input logic [7:0] d, input logic v,
                             input logic e, input logic [7:0] c, input logic b);
    chk({tag, "_data"}, 32'(frame_data), 32'(d));
    chk({tag, "_valid"}, 32'(frame_valid), 32'(v));
    chk({tag, "_count"}, 32'(frame_count), 32'(c));
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    if (v) chk({tag, "_perr"}, 32'(parity_error), 32'(e));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, limit 400000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p;
    #1 lit_outputs("reset", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2 Reset = 1'b1;

    send_frame(8'hA5, 1'b0, 1'b0); settle();
    lit_outputs("good", 8'hA5, 1'b1, 1'b0, 8'd1, 1'b0);
    @(negedge clk); chk("good_strobe_end", 32'(frame_valid), 32'd0);

    send_frame(8'hA5, 1'b1, 1'b0); settle();
    lit_outputs("badpar", 8'hA5, 1'b1, 1'b1, 8'd1, 1'b0);

    repeat (2) step(1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1); settle();
    lit_outputs("ignore", 8'hA5, 1'b1, 1'b0, 8'd2, 1'b0);
    @(negedge clk); lit_outputs("ignore_after", 8'hA5, 1'b0, 1'b0, 8'd2, 1'b0);

    send_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0); settle();
    lit_outputs("b2b", 8'h3C, 1'b1, 1'b0, 8'd4, 1'b0);

    for (int i = 0; i < 5; i++) step((i % 2) == 0, i == 0);
    @(posedge clk); #2 Reset = 1'b0;
    #1 lit_outputs("midreset", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
    data = 1'b0; detected = 1'b0;
    repeat (2) @(posedge clk);
    #2 Reset = 1'b1;
    repeat (3) step(1'b1, 1'b0);
    lit_outputs("postreset_idle", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0); settle();
    lit_outputs("postreset", 8'hA5, 1'b1, 1'b0, 8'd1, 1'b0);

    @(posedge clk); #2 Reset = 1'b0;
    @(posedge clk); #2 Reset = 1'b1;
    for (int i = 0; i < 255; i++) begin
      p = 8'($urandom);
      send_frame(p, ^p, 1'b0);
    end
    settle();
    chk("wrap_255", 32'(frame_count), 32'd255);
    send_frame(8'h3C, 1'b0, 1'b0); settle();
    chk("wrap_0", 32'(frame_count), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      Reset    = ($urandom_range(0, 399) != 0);
      data     = 1'($urandom);
      detected = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #2;
    Reset = 1'b1; data = 1'b0; detected = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
